rcc_clkgen_multi: RTL and testbench

- Parametrised successor to the AHB reset-and-clock-control block.
- Generates NUM_CH independent divided clocks, each with:
  - an HCLK-synchronous clock-enable pulse
  - a sequenced active-low peripheral reset
- All channels are programmed through an AHB-Lite slave register file.
- Adds behaviour the fixed-function RCC lacks: per-channel runtime divider, glitch-free gating, auto-gating on a per-channel activity request, and counted reset-release.

---
 rtl/rcc_clkgen_multi.sv | 222 ++++++++++++++++++++++
 tb/tb_rcc_clkgen_multi.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_clkgen_multi.sv
// rcc_clkgen_multi: AHB-programmed bank of divided clocks
// with glitch-free gating and sequenced peripheral resets.
module rcc_clkgen_multi #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int RST_HOLD = 4,
  parameter int DIV_RST  = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [11:0]       HADDR,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  input  logic [NUM_CH-1:0] CH_ACTIVE,
  output logic [NUM_CH-1:0] CH_CLK,
  output logic [NUM_CH-1:0] CH_CLKEN,
  output logic [NUM_CH-1:0] CH_RESETn
);

  localparam int CW     = DIV_W + 1;
  localparam int IDX_SW = 32;
  localparam int IDX_ST = 33;

  typedef enum logic [1:0] {
    S_RST,
    S_HOLD,
    S_RUN
  } rst_st_e;

  logic              ap_vld_q, ap_vld_d;
  logic              ap_wr_q, ap_wr_d;
  logic [9:0]        ap_idx_q, ap_idx_d;
  logic              wr_en;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ag_q, ag_d;
  logic [NUM_CH-1:0] sw_q, sw_d;
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  div_d [NUM_CH];

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  dact_q [NUM_CH];
  logic [DIV_W-1:0]  dact_d [NUM_CH];
  logic [NUM_CH-1:0] gated_q, gated_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] clken_q, clken_d;
  logic [NUM_CH-1:0] rstn_v;

  logic              rd_ctrl, rd_sw, rd_st;
  logic              unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[1:0], HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign CH_CLK    = clk_q;
  assign CH_CLKEN  = clken_q;
  assign CH_RESETn = rstn_v;

  // Address-phase capture and register-file write decode
  always_comb begin
    ap_vld_d = HSEL & HREADY & HTRANS[1];
    ap_wr_d  = HWRITE;
    ap_idx_d = HADDR[11:2];
    wr_en    = ap_vld_q & ap_wr_q;
    en_d     = en_q;
    ag_d     = ag_q;
    sw_d     = sw_q;
    div_d    = div_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && ap_idx_q == 10'(i)) begin
        en_d[i]  = HWDATA[0];
        ag_d[i]  = HWDATA[1];
        div_d[i] = HWDATA[8 +: DIV_W];
      end
    end
    if (wr_en && ap_idx_q == 10'(IDX_SW)) begin
      sw_d = HWDATA[NUM_CH-1:0];
    end
  end

  // Bus pipeline and control registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_vld_q <= 1'b0;
      ap_wr_q  <= 1'b0;
      ap_idx_q <= '0;
      en_q     <= '0;
      ag_q     <= '0;
      sw_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DIV_RST);
      end
    end else begin
      ap_vld_q <= ap_vld_d;
      ap_wr_q  <= ap_wr_d;
      ap_idx_q <= ap_idx_d;
      en_q     <= en_d;
      ag_q     <= ag_d;
      sw_q     <= sw_d;
      div_q    <= div_d;
    end
  end

  // Read data mux, driven only during a read data phase
  always_comb begin
    HRDATA  = '0;
    rd_ctrl = ap_idx_q < 10'(NUM_CH);
    rd_sw   = ap_idx_q == 10'(IDX_SW);
    rd_st   = ap_idx_q == 10'(IDX_ST);
    if (ap_vld_q & ~ap_wr_q) begin
      unique case (1'b1)
        rd_ctrl: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ap_idx_q == 10'(i)) begin
              HRDATA[0]          = en_q[i];
              HRDATA[1]          = ag_q[i];
              HRDATA[8 +: DIV_W] = div_q[i];
            end
          end
        end
        rd_sw:   HRDATA[NUM_CH-1:0] = sw_q;
        rd_st:   HRDATA[NUM_CH-1:0] = rstn_v;
        default: HRDATA = '0;
      endcase
    end
  end

  // Divider: gate and divisor only change at a period boundary
  always_comb begin
    logic         gate_req;
    logic         bnd;
    logic [CW-1:0] half;
    for (int i = 0; i < NUM_CH; i++) begin
      gate_req   = ~en_q[i] | (ag_q[i] & ~CH_ACTIVE[i]);
      bnd        = cnt_q[i] == dact_q[i];
      cnt_d[i]   = cnt_q[i] + DIV_W'(1);
      dact_d[i]  = dact_q[i];
      gated_d[i] = gated_q[i];
      if ((gated_q[i] & ~en_q[i]) | bnd) begin
        cnt_d[i]   = '0;
        dact_d[i]  = div_q[i];
        gated_d[i] = gate_req;
      end
      half       = ({1'b0, dact_d[i]} >> 1) + CW'(1);
      clken_d[i] = ~gated_d[i] & (cnt_d[i] == '0);
      clk_d[i]   = ~gated_d[i] & ({1'b0, cnt_d[i]} < half);
    end
  end

  // Divider state and registered clock outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      gated_q <= '1;
      clk_q   <= '0;
      clken_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        dact_q[i] <= DIV_W'(DIV_RST);
      end
    end else begin
      gated_q <= gated_d;
      clk_q   <= clk_d;
      clken_q <= clken_d;
      cnt_q   <= cnt_d;
      dact_q  <= dact_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rst
    rst_st_e    st_q;
    logic [7:0] hold_q;
    logic [7:0] hold_nx;
    logic       rstn_q;

    assign hold_nx   = hold_q + {7'd0, clken_q[g]};
    assign rstn_v[g] = rstn_q;

    // Reset sequencer: release after RST_HOLD divided-clock pulses
    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        st_q   <= S_RST;
        hold_q <= '0;
        rstn_q <= 1'b0;
      end else if (sw_q[g] | ~en_q[g]) begin
        st_q   <= S_RST;
        rstn_q <= 1'b0;
      end else begin
        unique case (st_q)
          S_RST: begin
            st_q   <= S_HOLD;
            hold_q <= '0;
            rstn_q <= 1'b0;
          end
          S_HOLD: begin
            hold_q <= hold_nx;
            if (hold_nx == 8'(RST_HOLD)) begin
              st_q   <= S_RUN;
              rstn_q <= 1'b1;
            end
          end
          S_RUN: begin
            rstn_q <= 1'b1;
          end
          default: begin
            st_q   <= S_RST;
            rstn_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rcc_clkgen_multi.sv
// tb_rcc_clkgen_multi: randomized bench with a period-level
// reference model and a read-data scoreboard.
module tb_rcc_clkgen_multi;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int RH  = 4;
  localparam int DR  = 1;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic            HSEL = 1'b0;
  logic            HREADY = 1'b1;
  logic [1:0]      HTRANS = 2'b00;
  logic [2:0]      HSIZE = 3'b010;
  logic            HWRITE = 1'b0;
  logic [11:0]     HADDR = '0;
  logic [31:0]     HWDATA = '0;
  logic            HREADYOUT;
  logic            HRESP;
  logic [31:0]     HRDATA;
  logic [NCH-1:0]  CH_ACTIVE = '0;
  logic [NCH-1:0]  CH_CLK;
  logic [NCH-1:0]  CH_CLKEN;
  logic [NCH-1:0]  CH_RESETn;

  rcc_clkgen_multi #(
    .NUM_CH(NCH), .DIV_W(DW),
    .RST_HOLD(RH), .DIV_RST(DR)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA),
    .CH_ACTIVE(CH_ACTIVE), .CH_CLK(CH_CLK),
    .CH_CLKEN(CH_CLKEN), .CH_RESETn(CH_RESETn)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: registers, period position, reset phase
  bit             m_en [NCH];
  bit             m_ag [NCH];
  bit             m_sw [NCH];
  int             m_div [NCH];
  int             pos [NCH];
  int             plen [NCH];
  bit             off [NCH];
  int             ph [NCH];
  int             hn [NCH];
  logic [NCH-1:0] e_clk, e_clken, e_rstn;
  bit             pv, pw, rd_ph;
  int             pa;
  logic [31:0]    exp_q [$];
  logic [31:0]    pend_wd = '0;

  function void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_ag[c] = 0; m_sw[c] = 0;
      m_div[c] = DR;
      pos[c] = 0; plen[c] = DR + 1; off[c] = 1;
      ph[c] = 0; hn[c] = 0;
    end
    e_clk = '0; e_clken = '0; e_rstn = '0;
    pv = 0; pw = 0; pa = 0; rd_ph = 0;
    exp_q.delete();
  endfunction

  function logic [31:0] m_read(int idx);
    logic [31:0] r;
    r = '0;
    if (idx < NCH) begin
      r[0] = m_en[idx];
      r[1] = m_ag[idx];
      r[15:8] = 8'(m_div[idx]);
    end else if (idx == 32) begin
      for (int c = 0; c < NCH; c++) r[c] = m_sw[c];
    end else if (idx == 33) begin
      r[NCH-1:0] = e_rstn;
    end
    return r;
  endfunction

  function void m_write(int idx, logic [31:0] d);
    if (idx < NCH) begin
      m_en[idx] = d[0];
      m_ag[idx] = d[1];
      m_div[idx] = int'(d[15:8]);
    end else if (idx == 32) begin
      for (int c = 0; c < NCH; c++) m_sw[c] = d[c];
    end
  endfunction

  // model advances one HCLK period per rising edge
  initial begin
    m_reset();
    forever begin
      @(posedge HCLK or posedge HRESET);
      if (HRESET) begin
        m_reset();
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (m_sw[c] || !m_en[c]) ph[c] = 0;
          else if (ph[c] == 0) begin
            ph[c] = 1; hn[c] = 0;
          end else if (ph[c] == 1) begin
            hn[c] += int'(e_clken[c]);
            if (hn[c] == RH) ph[c] = 2;
          end
        end
        for (int c = 0; c < NCH; c++) begin
          if ((off[c] && !m_en[c]) || pos[c] == plen[c] - 1) begin
            pos[c] = 0;
            plen[c] = m_div[c] + 1;
            off[c] = !m_en[c] || (m_ag[c] && !CH_ACTIVE[c]);
          end else begin
            pos[c]++;
          end
          e_clk[c] = !off[c] && (2 * pos[c] < plen[c]);
          e_clken[c] = !off[c] && pos[c] == 0;
          e_rstn[c] = ph[c] == 2;
        end
        if (pv && pw) m_write(pa, HWDATA);
        pv = HSEL && HREADY && HTRANS[1];
        pw = HWRITE;
        pa = int'(HADDR[11:2]);
        rd_ph = pv && !pw;
        if (rd_ph) exp_q.push_back(m_read(pa));
      end
    end
  end

  // monitor: per-cycle outputs and scoreboard pops on read data phases
  initial begin
    logic [31:0] ex;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        n_cmp++;
        if ({CH_CLK, CH_CLKEN, CH_RESETn, HREADYOUT, HRESP}
            !== {e_clk, e_clken, e_rstn, 2'b10}) begin
          n_err++;
          $display("FAIL outs t=%0t got clk=%b en=%b rstn=%b rdy=%b resp=%b want clk=%b en=%b rstn=%b rdy=1 resp=0",
                   $time, CH_CLK, CH_CLKEN, CH_RESETn, HREADYOUT, HRESP,
                   e_clk, e_clken, e_rstn);
        end
        if (rd_ph) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rdata t=%0t got %h want <none queued>",
                     $time, HRDATA);
          end else begin
            ex = exp_q.pop_front();
            if (HRDATA !== ex) begin
              n_err++;
              $display("FAIL rdata t=%0t got %h want %h",
                       $time, HRDATA, ex);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, got, want);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr,
                       input logic w, input logic [11:0] a,
                       input logic [31:0] d);
    HWDATA = pend_wd;
    HSEL = sel;
    HTRANS = tr;
    HWRITE = w;
    HADDR = a;
    pend_wd = d;
    @(negedge HCLK);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    drive(1'b1, 2'b10, 1'b1, a, d);
  endtask

  task automatic rd(input logic [11:0] a);
    drive(1'b1, 2'b10, 1'b0, a, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  task automatic rand_ops(input int n);
    logic [31:0] rv, d;
    logic [11:0] a;
    logic [1:0]  tr;
    logic        sel, w;
    int          k;
    repeat (n) begin
      rv = $urandom();
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, NCH - 1);
        CH_ACTIVE[k] = ~CH_ACTIVE[k];
      end
      HREADY = $urandom_range(0, 9) != 0;
      sel = $urandom_range(0, 9) != 0;
      tr = ($urandom_range(0, 1) == 0) ? 2'b10
                                        : 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      a = '0;
      d = rv;
      case (k)
        0, 1, 2, 3: begin
          a = 12'(k * 4);
          d = (rv & 32'hFFFF_00FC)
            | (32'($urandom_range(0, 7)) << 8)
            | (32'($urandom_range(0, 1)) << 1)
            | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
        end
        4: begin
          a = 12'h080;
          d = ($urandom_range(0, 3) == 0) ? (rv & 32'hF) : 32'd0;
        end
        5: a = 12'h084;
        6: a = 12'h0F0;
        7: a = {rv[11:2], 2'b00};
        default: sel = 1'b0;
      endcase
      drive(sel, tr, w, a, d);
    end
    HREADY = 1'b1;
    idle(2);
  endtask

  task automatic async_reset();
    wr(12'h000, 32'h0000_0301);
    idle(20);
    #2 HRESET = 1'b1;
    #1;
    chk("async_clk", 32'(CH_CLK), '0);
    chk("async_clken", 32'(CH_CLKEN), '0);
    chk("async_rstn", 32'(CH_RESETn), '0);
    chk("async_hrdata", HRDATA, '0);
    pend_wd = '0;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    idle(1);
  endtask

  initial begin
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("rst_clk", 32'(CH_CLK), '0);
    chk("rst_clken", 32'(CH_CLKEN), '0);
    chk("rst_rstn", 32'(CH_RESETn), '0);
    chk("rst_hrdata", HRDATA, '0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), '0);
    HRESET = 1'b0;
    idle(2);
    rd(12'h000);
    idle(2);

    wr(12'h000, 32'h0000_0301);
    idle(30);
    rd(12'h084);
    rd(12'h000);
    idle(1);
    wr(12'h000, 32'h0000_0601);
    idle(30);

    CH_ACTIVE[1] = 1'b0;
    wr(12'h004, 32'h0000_0203);
    idle(8);
    CH_ACTIVE[1] = 1'b1;
    idle(14);
    CH_ACTIVE[1] = 1'b0;
    idle(10);

    wr(12'h080, 32'h0000_0001);
    rd(12'h080);
    idle(8);
    wr(12'h080, 32'h0000_0000);
    idle(40);
    rd(12'h084);

    wr(12'h0F0, 32'hFFFF_FFFF);
    rd(12'h0F0);
    rd(12'h000);
    rd(12'h004);
    rd(12'h080);
    idle(2);

    rand_ops(800);
    async_reset();
    rd(12'h000);
    rd(12'h004);
    rd(12'h080);
    rd(12'h084);
    idle(2);
    rand_ops(400);

    idle(5);
    chk("sb_empty", 32'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
